// File: rtl/throw_sequencer.sv
// Turn/throw sequencer for the cat-vs-dog duel: alternates turns, charges local power,
// draws a fresh wind value each turn and issues a one-cycle launch to the projectile datapath.
module throw_sequencer #(
  parameter int         TICK_DIV       = 6_000_000,
  parameter int         FLIGHT_TIMEOUT = 300_000_000,
  parameter int         RESULT_HOLD    = 60_000_000,
  parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
  input  logic       clk60MHz,
  input  logic       rst,
  input  logic       start,
  input  logic       local_player,
  input  logic       fire_hold,
  input  logic       in_fire,
  input  logic       flight_done,
  input  logic       game_over,
  output logic       turn,
  output logic [3:0] power,
  output logic [2:0] wind,
  output logic       launch,
  output logic       busy
);

  localparam int MAX_A   = (TICK_DIV > FLIGHT_TIMEOUT) ? TICK_DIV : FLIGHT_TIMEOUT;
  localparam int MAX_CNT = (MAX_A > RESULT_HOLD) ? MAX_A : RESULT_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] FLIGHT_LAST = CW'(FLIGHT_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESULT_HOLD - 1);
  localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AIM    = 3'd1;
  localparam logic [2:0] ST_CHARGE = 3'd2;
  localparam logic [2:0] ST_LAUNCH = 3'd3;
  localparam logic [2:0] ST_FLIGHT = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;
  localparam logic [2:0] ST_SWITCH = 3'd6;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting left; nonzero states stay nonzero.
  function automatic logic [7:0] lfsr_step(input logic [7:0] value);
    return {value[6:0], value[7] ^ value[5] ^ value[4] ^ value[3]};
  endfunction

  logic [2:0]    state_r, state_s;
  logic          turn_r, turn_s;
  logic [3:0]    power_r, power_s;
  logic [7:0]    lfsr_r, lfsr_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          my_turn_s;

  assign my_turn_s = (turn_r == local_player);

  // Next-state, power, turn, wind and shared phase counter.
  always_comb begin
    state_s = state_r;
    turn_s  = turn_r;
    power_s = power_r;
    lfsr_s  = lfsr_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_AIM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AIM: begin
        if (my_turn_s && fire_hold) begin
          state_s = ST_CHARGE;
          power_s = 4'd1;
          cnt_s   = CNT_ZERO;
        end else if (!my_turn_s && in_fire) begin
          state_s = ST_LAUNCH;
        end else begin
          state_s = ST_AIM;
        end
      end
      ST_CHARGE: begin
        // The step still lands when the button is released on the terminal tick.
        if (cnt_r == TICK_LAST) begin
          cnt_s = CNT_ZERO;
          if (power_r != 4'd15) begin
            power_s = power_r + 4'd1;
          end else begin
            power_s = power_r;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
        if (!fire_hold) begin
          state_s = ST_LAUNCH;
        end else begin
          state_s = ST_CHARGE;
        end
      end
      ST_LAUNCH: begin
        state_s = ST_FLIGHT;
        cnt_s   = CNT_ZERO;
      end
      ST_FLIGHT: begin
        if (flight_done || (cnt_r == FLIGHT_LAST)) begin
          state_s = ST_RESULT;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_RESULT: begin
        if (cnt_r == HOLD_LAST) begin
          cnt_s = CNT_ZERO;
          if (game_over) begin
            state_s = ST_IDLE;
            turn_s  = 1'b0;
          end else begin
            state_s = ST_SWITCH;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SWITCH: begin
        state_s = ST_AIM;
        turn_s  = ~turn_r;
        power_s = 4'd0;
        lfsr_s  = lfsr_step(lfsr_r);
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_r <= ST_IDLE;
      turn_r  <= 1'b0;
      power_r <= 4'd0;
      lfsr_r  <= LFSR_SEED;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      turn_r  <= turn_s;
      power_r <= power_s;
      lfsr_r  <= lfsr_s;
      cnt_r   <= cnt_s;
    end
  end

  assign turn   = turn_r;
  assign power  = power_r;
  assign wind   = lfsr_r[2:0];
  assign launch = (state_r == ST_LAUNCH);
  assign busy   = (state_r == ST_CHARGE) || (state_r == ST_LAUNCH) ||
                  (state_r == ST_FLIGHT) || (state_r == ST_RESULT);

endmodule

// File: tb/tb_throw_sequencer.sv
// Bench for throw_sequencer: directed scenarios followed by randomized turns, checked
// against a per-turn model built from hold time, flight time and the wind polynomial.
module tb_throw_sequencer;

  localparam int         TICK_DIV       = 4;
  localparam int         FLIGHT_TIMEOUT = 20;
  localparam int         RESULT_HOLD    = 5;
  localparam logic [7:0] SEED           = 8'hA5;
  localparam int         NO_DONE        = 1000;

  logic       clk60MHz = 1'b0;
  logic       rst = 1'b1, start = 1'b0, local_player = 1'b0, fire_hold = 1'b0;
  logic       in_fire = 1'b0, flight_done = 1'b0, game_over = 1'b0;
  logic       turn, launch, busy;
  logic [3:0] power;
  logic [2:0] wind;

  int n_cmp = 0;
  int n_bad = 0;
  int m_turn, m_power, m_lfsr;

  throw_sequencer #(
    .TICK_DIV(TICK_DIV), .FLIGHT_TIMEOUT(FLIGHT_TIMEOUT),
    .RESULT_HOLD(RESULT_HOLD), .LFSR_SEED(SEED)
  ) dut (
    .clk60MHz(clk60MHz), .rst(rst), .start(start), .local_player(local_player),
    .fire_hold(fire_hold), .in_fire(in_fire), .flight_done(flight_done),
    .game_over(game_over), .turn(turn), .power(power), .wind(wind),
    .launch(launch), .busy(busy)
  );

  always #8 clk60MHz = ~clk60MHz;

  task automatic tick();
    @(posedge clk60MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Polynomial x^8+x^6+x^5+x^4+1 as integer arithmetic: feedback is the parity of bits 7,5,4,3.
  function automatic int wind_poly_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  task automatic model_reset();
    m_turn  = 0;
    m_power = 0;
    m_lfsr  = int'(SEED);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_turn"}, turn, 0);
    check({tag, "_power"}, power, 0);
    check({tag, "_wind"}, wind, int'(SEED) & 7);
    check({tag, "_launch"}, launch, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic begin_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("aim_not_busy", busy, 0);
  endtask

  // k = number of CHARGE cycles including the release cycle.
  task automatic local_throw(input int k);
    bit glitch;
    glitch = 1'b0;
    fire_hold = 1'b1;
    tick();
    check("charge_entry_power", power, 1);
    for (int i = 1; i < k; i++) begin
      tick();
      if (launch || !busy || power == 4'd0) glitch = 1'b1;
    end
    fire_hold = 1'b0;
    tick();
    m_power = (1 + k / TICK_DIV > 15) ? 15 : 1 + k / TICK_DIV;
    check("charge_glitch", glitch, 0);
    check("launch_local", launch, 1);
    check("launch_power", power, m_power);
    check("launch_turn", turn, m_turn);
  endtask

  task automatic remote_throw(input int r);
    bit leak;
    leak = 1'b0;
    fire_hold = 1'b1;
    for (int i = 0; i < r; i++) begin
      tick();
      if (busy || launch) leak = 1'b1;
    end
    fire_hold = 1'b0;
    in_fire = 1'b1;
    tick();
    in_fire = 1'b0;
    check("remote_ignores_fire", leak, 0);
    check("launch_remote", launch, 1);
    check("remote_power", power, m_power);
  endtask

  // done_at = FLIGHT cycle index carrying flight_done (NO_DONE for none).
  task automatic flight(input int done_at, input bit gover);
    int  n, exp_f;
    bit  unstable, ended;
    n = 0;
    unstable = 1'b0;
    ended = 1'b0;
    game_over = gover;
    for (int j = 0; j < 200 && !ended; j++) begin
      flight_done = (j == done_at + 1);
      tick();
      flight_done = 1'b0;
      if (busy) begin
        n++;
        if (launch || turn !== m_turn[0] || power !== m_power[3:0]) unstable = 1'b1;
      end else begin
        ended = 1'b1;
      end
    end
    game_over = 1'b0;
    exp_f = (done_at < FLIGHT_TIMEOUT) ? done_at + 1 : FLIGHT_TIMEOUT;
    check("flight_stable", unstable, 0);
    check("busy_span", n, exp_f + RESULT_HOLD);
    if (gover) begin
      m_turn = 0;
      check("gameover_turn", turn, 0);
      check("gameover_power", power, m_power);
      fire_hold = 1'b1;
      in_fire = 1'b1;
      repeat (3) tick();
      fire_hold = 1'b0;
      in_fire = 1'b0;
      check("idle_needs_start", busy | launch, 0);
    end else begin
      check("switch_turn_hold", turn, m_turn);
      tick();
      m_turn  = m_turn ^ 1;
      m_power = 0;
      m_lfsr  = wind_poly_next(m_lfsr);
      check("switch_turn", turn, m_turn);
      check("switch_power", power, 0);
      check("switch_wind", wind, m_lfsr & 7);
    end
  endtask

  initial begin
    int done_at;
    bit gover;

    // Reset and IDLE ignoring everything but start.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");
    fire_hold = 1'b1;
    in_fire = 1'b1;
    repeat (3) tick();
    fire_hold = 1'b0;
    in_fire = 1'b0;
    check("idle_ignore", busy | launch, 0);
    begin_game();

    // Ten cycles of fire_hold, then a timed-out flight and a turn switch.
    local_player = 1'b0;
    local_throw(10);
    check("hold10_power", power, 3);
    flight(NO_DONE, 1'b0);

    // Remote turn: local fire ignored, in_fire launches next cycle.
    remote_throw(4);
    flight(3, 1'b0);

    // Saturation, then game over back to IDLE.
    local_throw(100);
    check("saturate_power", power, 15);
    flight(5, 1'b1);

    // Reset during CHARGE.
    begin_game();
    fire_hold = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fire_hold = 1'b0;
    model_reset();
    check_reset_outputs("rst_charge");
    tick();
    check("rst_charge_idle", busy, 0);

    // Reset during FLIGHT.
    begin_game();
    local_throw(2);
    repeat (2) tick();
    check("pre_rst_flight_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check_reset_outputs("rst_flight");

    // Randomized turns.
    begin_game();
    for (int t = 0; t < 30; t++) begin
      local_player = 1'($urandom_range(0, 1));
      if (int'(local_player) == m_turn) begin
        if ($urandom_range(0, 2) == 0) begin
          in_fire = 1'b1;
          tick();
          in_fire = 1'b0;
          check("aim_ignore_in_fire", busy, 0);
        end
        local_throw(int'($urandom_range(1, 70)));
      end else begin
        remote_throw(int'($urandom_range(0, 5)));
      end
      done_at = ($urandom_range(0, 3) == 0) ? NO_DONE : int'($urandom_range(0, 24));
      gover = ($urandom_range(0, 7) == 0);
      flight(done_at, gover);
      if (gover) begin_game();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
